// File: rtl/dma_hif_arbiter.sv
// Round-robin arbiter sharing the DMA host-interface port between the TX and RX DMA engines.
// Optional stall watchdog is enabled by defining RW_HIF_ARB_WDOG_EN.
module dma_hif_arbiter #(
  parameter int WDOG_LIMIT = 1023
) (
  input  logic        macPIClk,
  input  logic        macPIClkHardRst,
  // TX requester
  input  logic        txHIFRead,
  input  logic        txHIFWrite,
  input  logic [31:0] txHIFAddressIn,
  input  logic [2:0]  txHIFSize,
  input  logic [31:0] txHIFWriteDataIn,
  output logic [31:0] txHIFReadDataOut,
  output logic        txHIFReadDataValid,
  output logic        txHIFReady,
  output logic        txHIFTransComplete,
  output logic        txHIFError,
  // RX requester
  input  logic        rxHIFRead,
  input  logic        rxHIFWrite,
  input  logic [31:0] rxHIFAddressIn,
  input  logic [2:0]  rxHIFSize,
  input  logic [31:0] rxHIFWriteDataIn,
  output logic [31:0] rxHIFReadDataOut,
  output logic        rxHIFReadDataValid,
  output logic        rxHIFReady,
  output logic        rxHIFTransComplete,
  output logic        rxHIFError,
  // AHB master interface
  output logic        dmaHIFRead,
  output logic        dmaHIFWrite,
  output logic [31:0] dmaHIFAddressIn,
  output logic [2:0]  dmaHIFSize,
  output logic [31:0] dmaHIFWriteDataIn,
  input  logic [31:0] dmaHIFReadDataOut,
  input  logic        dmaHIFReadDataValid,
  input  logic        dmaHIFReady,
  input  logic        dmaHIFTransComplete,
  input  logic        dmaHIFError,
  // status
  output logic [1:0]  arbGrant,
  output logic        arbWdogErr
);

  // state  | meaning
  // IDLE   | no grant; one dead cycle after every completion
  // GNT_TX | TX owns the downstream port until complete/error
  // GNT_RX | RX owns the downstream port until complete/error
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_TX = 2'd1,
    GNT_RX = 2'd2
  } arbState_t;

  arbState_t state, stateNext;
  logic      lastGrant, lastGrantNext;   // 0 = TX, 1 = RX
  logic      txReq, rxReq, transDone, wdogFire;

  assign txReq     = txHIFRead | txHIFWrite;
  assign rxReq     = rxHIFRead | rxHIFWrite;
  assign transDone = dmaHIFTransComplete | dmaHIFError;

  always_ff @(posedge macPIClk or posedge macPIClkHardRst) begin
    if (macPIClkHardRst) begin
      state     <= IDLE;
      lastGrant <= 1'b1;
    end else begin
      state     <= stateNext;
      lastGrant <= lastGrantNext;
    end
  end

  always_comb begin
    stateNext     = state;
    lastGrantNext = lastGrant;
    case (state)
      IDLE: begin
        if (txReq && (!rxReq || lastGrant)) begin
          stateNext     = GNT_TX;
          lastGrantNext = 1'b0;
        end else if (rxReq) begin
          stateNext     = GNT_RX;
          lastGrantNext = 1'b1;
        end
      end
      GNT_TX, GNT_RX: begin
        if (transDone || wdogFire) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Muxing is purely combinational from the registered state so a grant adds no latency.
  always_comb begin
    dmaHIFRead         = 1'b0;
    dmaHIFWrite        = 1'b0;
    dmaHIFAddressIn    = '0;
    dmaHIFSize         = '0;
    dmaHIFWriteDataIn  = '0;
    txHIFReadDataOut   = '0;
    txHIFReadDataValid = 1'b0;
    txHIFReady         = 1'b0;
    txHIFTransComplete = 1'b0;
    txHIFError         = 1'b0;
    rxHIFReadDataOut   = '0;
    rxHIFReadDataValid = 1'b0;
    rxHIFReady         = 1'b0;
    rxHIFTransComplete = 1'b0;
    rxHIFError         = 1'b0;
    arbGrant           = 2'b00;
    case (state)
      GNT_TX: begin
        arbGrant           = 2'b01;
        dmaHIFRead         = txHIFRead & ~wdogFire;
        dmaHIFWrite        = txHIFWrite & ~wdogFire;
        dmaHIFAddressIn    = txHIFAddressIn;
        dmaHIFSize         = txHIFSize;
        dmaHIFWriteDataIn  = txHIFWriteDataIn;
        txHIFReadDataOut   = dmaHIFReadDataOut;
        txHIFReadDataValid = dmaHIFReadDataValid;
        txHIFReady         = dmaHIFReady;
        txHIFTransComplete = dmaHIFTransComplete;
        txHIFError         = dmaHIFError | wdogFire;
      end
      GNT_RX: begin
        arbGrant           = 2'b10;
        dmaHIFRead         = rxHIFRead & ~wdogFire;
        dmaHIFWrite        = rxHIFWrite & ~wdogFire;
        dmaHIFAddressIn    = rxHIFAddressIn;
        dmaHIFSize         = rxHIFSize;
        dmaHIFWriteDataIn  = rxHIFWriteDataIn;
        rxHIFReadDataOut   = dmaHIFReadDataOut;
        rxHIFReadDataValid = dmaHIFReadDataValid;
        rxHIFReady         = dmaHIFReady;
        rxHIFTransComplete = dmaHIFTransComplete;
        rxHIFError         = dmaHIFError | wdogFire;
      end
      default: ;
    endcase
  end

`ifdef RW_HIF_ARB_WDOG_EN
  localparam logic [9:0] WdogTerm = 10'(WDOG_LIMIT - 1);

  logic [9:0] wdogCnt;
  logic       wdogErrQ;
  logic       stall;

  // A stall cycle is a granted cycle with no handshake progress; the Nth one fires.
  assign stall    = (state != IDLE) & ~(dmaHIFReady | dmaHIFReadDataValid);
  assign wdogFire = stall & ~transDone & (wdogCnt == WdogTerm);

  always_ff @(posedge macPIClk or posedge macPIClkHardRst) begin
    if (macPIClkHardRst) begin
      wdogCnt  <= '0;
      wdogErrQ <= 1'b0;
    end else begin
      if (!stall || transDone || wdogFire) wdogCnt <= '0;
      else                                 wdogCnt <= wdogCnt + 10'd1;
      if (wdogFire) wdogErrQ <= 1'b1;
    end
  end

  assign arbWdogErr = wdogErrQ;
`else
  logic unusedWdogLimit;
  assign unusedWdogLimit = |10'(WDOG_LIMIT);
  assign wdogFire        = 1'b0;
  assign arbWdogErr      = 1'b0;
`endif

endmodule

// File: tb/tb_dma_hif_arbiter.sv
// Directed self-checking bench for dma_hif_arbiter; watchdog checks run when RW_HIF_ARB_WDOG_EN is defined.
module tb_dma_hif_arbiter;

`ifdef RW_HIF_ARB_WDOG_EN
  localparam int TbWdog = 8;
`else
  localparam int TbWdog = 1023;
`endif

  logic        macPIClk = 1'b0;
  logic        macPIClkHardRst;
  logic        txHIFRead, txHIFWrite, rxHIFRead, rxHIFWrite;
  logic [31:0] txHIFAddressIn, txHIFWriteDataIn, rxHIFAddressIn, rxHIFWriteDataIn;
  logic [2:0]  txHIFSize, rxHIFSize;
  logic [31:0] txHIFReadDataOut, rxHIFReadDataOut;
  logic        txHIFReadDataValid, txHIFReady, txHIFTransComplete, txHIFError;
  logic        rxHIFReadDataValid, rxHIFReady, rxHIFTransComplete, rxHIFError;
  logic        dmaHIFRead, dmaHIFWrite;
  logic [31:0] dmaHIFAddressIn, dmaHIFWriteDataIn, dmaHIFReadDataOut;
  logic [2:0]  dmaHIFSize;
  logic        dmaHIFReadDataValid, dmaHIFReady, dmaHIFTransComplete, dmaHIFError;
  logic [1:0]  arbGrant;
  logic        arbWdogErr;

  int nCompared   = 0;
  int nMismatched = 0;

  always #5 macPIClk = ~macPIClk;

  dma_hif_arbiter #(.WDOG_LIMIT(TbWdog)) dut (
    .macPIClk(macPIClk), .macPIClkHardRst(macPIClkHardRst),
    .txHIFRead(txHIFRead), .txHIFWrite(txHIFWrite), .txHIFAddressIn(txHIFAddressIn),
    .txHIFSize(txHIFSize), .txHIFWriteDataIn(txHIFWriteDataIn), .txHIFReadDataOut(txHIFReadDataOut),
    .txHIFReadDataValid(txHIFReadDataValid), .txHIFReady(txHIFReady),
    .txHIFTransComplete(txHIFTransComplete), .txHIFError(txHIFError),
    .rxHIFRead(rxHIFRead), .rxHIFWrite(rxHIFWrite), .rxHIFAddressIn(rxHIFAddressIn),
    .rxHIFSize(rxHIFSize), .rxHIFWriteDataIn(rxHIFWriteDataIn), .rxHIFReadDataOut(rxHIFReadDataOut),
    .rxHIFReadDataValid(rxHIFReadDataValid), .rxHIFReady(rxHIFReady),
    .rxHIFTransComplete(rxHIFTransComplete), .rxHIFError(rxHIFError),
    .dmaHIFRead(dmaHIFRead), .dmaHIFWrite(dmaHIFWrite), .dmaHIFAddressIn(dmaHIFAddressIn),
    .dmaHIFSize(dmaHIFSize), .dmaHIFWriteDataIn(dmaHIFWriteDataIn), .dmaHIFReadDataOut(dmaHIFReadDataOut),
    .dmaHIFReadDataValid(dmaHIFReadDataValid), .dmaHIFReady(dmaHIFReady),
    .dmaHIFTransComplete(dmaHIFTransComplete), .dmaHIFError(dmaHIFError),
    .arbGrant(arbGrant), .arbWdogErr(arbWdogErr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 2 time units after a rising edge, outputs are checked 1 unit later.
  task automatic tick();
    @(posedge macPIClk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clearIn();
    txHIFRead = 0; txHIFWrite = 0; txHIFAddressIn = 0; txHIFSize = 0; txHIFWriteDataIn = 0;
    rxHIFRead = 0; rxHIFWrite = 0; rxHIFAddressIn = 0; rxHIFSize = 0; rxHIFWriteDataIn = 0;
    dmaHIFReadDataOut = 0; dmaHIFReadDataValid = 0; dmaHIFReady = 0;
    dmaHIFTransComplete = 0; dmaHIFError = 0;
  endtask

  task automatic doReset();
    macPIClkHardRst = 1;
    clearIn();
    tick();
    tick();
    macPIClkHardRst = 0;
    settle();
  endtask

  initial begin
    doReset();
    chk("rst_grant", {30'd0, arbGrant}, 32'h0);
    chk("rst_wdog", {31'd0, arbWdogErr}, 32'h0);

    // single TX read
    txHIFRead = 1; txHIFAddressIn = 32'h1000; txHIFSize = 3'd2;
    settle();
    chk("t1_c0_grant", {30'd0, arbGrant}, 32'h0);
    chk("t1_c0_dmaRd", {31'd0, dmaHIFRead}, 32'h0);
    tick(); settle();
    chk("t1_c1_grant", {30'd0, arbGrant}, 32'h1);
    chk("t1_c1_dmaRd", {31'd0, dmaHIFRead}, 32'h1);
    chk("t1_c1_addr", dmaHIFAddressIn, 32'h1000);
    chk("t1_c1_size", {29'd0, dmaHIFSize}, 32'h2);
    tick();
    dmaHIFReady = 1; dmaHIFReadDataValid = 1; dmaHIFReadDataOut = 32'hDEADBEEF;
    settle();
    chk("t1_c2_rdata", txHIFReadDataOut, 32'hDEADBEEF);
    chk("t1_c2_rvalid", {31'd0, txHIFReadDataValid}, 32'h1);
    chk("t1_c2_rxRdata", rxHIFReadDataOut, 32'h0);
    chk("t1_c2_rxReady", {31'd0, rxHIFReady}, 32'h0);
    tick(); tick();
    dmaHIFReady = 0; dmaHIFReadDataValid = 0;
    tick();
    dmaHIFTransComplete = 1;
    settle();
    chk("t1_c5_cmpl", {31'd0, txHIFTransComplete}, 32'h1);
    chk("t1_c5_grant", {30'd0, arbGrant}, 32'h1);
    tick();
    dmaHIFTransComplete = 0; txHIFRead = 0;
    settle();
    chk("t1_c6_grant", {30'd0, arbGrant}, 32'h0);
    chk("t1_c6_cmpl", {31'd0, txHIFTransComplete}, 32'h0);

    // contention from reset: TX, RX, TX
    doReset();
    txHIFRead = 1; rxHIFRead = 1; txHIFAddressIn = 32'h10; rxHIFAddressIn = 32'h20;
    tick();
    dmaHIFTransComplete = 1;
    settle();
    chk("t2_first", {30'd0, arbGrant}, 32'h1);
    chk("t2_rxCmpl", {31'd0, rxHIFTransComplete}, 32'h0);
    tick();
    dmaHIFTransComplete = 0; txHIFRead = 0;
    settle();
    chk("t2_dead1", {30'd0, arbGrant}, 32'h0);
    txHIFRead = 1;
    tick();
    dmaHIFTransComplete = 1;
    settle();
    chk("t2_second", {30'd0, arbGrant}, 32'h2);
    chk("t2_addr", dmaHIFAddressIn, 32'h20);
    tick();
    dmaHIFTransComplete = 0; rxHIFRead = 0;
    settle();
    chk("t2_dead2", {30'd0, arbGrant}, 32'h0);
    tick(); settle();
    chk("t2_third", {30'd0, arbGrant}, 32'h1);
    dmaHIFTransComplete = 1;
    tick();
    dmaHIFTransComplete = 0; txHIFRead = 0;

    // RX write burst of 4 words
    rxHIFWrite = 1; rxHIFAddressIn = 32'h2000; rxHIFSize = 3'd2;
    tick();
    for (int i = 0; i < 4; i++) begin
      rxHIFWriteDataIn = 32'hA5A50000 + i;
      dmaHIFReady = 1;
      dmaHIFTransComplete = (i == 3);
      settle();
      chk($sformatf("t3_wdata%0d", i), dmaHIFWriteDataIn, 32'hA5A50000 + i);
      chk($sformatf("t3_wr%0d", i), {31'd0, dmaHIFWrite}, 32'h1);
      chk($sformatf("t3_size%0d", i), {29'd0, dmaHIFSize}, 32'h2);
      chk($sformatf("t3_txRdy%0d", i), {31'd0, txHIFReady}, 32'h0);
      chk($sformatf("t3_rxRdy%0d", i), {31'd0, rxHIFReady}, 32'h1);
      tick();
    end
    dmaHIFReady = 0; dmaHIFTransComplete = 0; rxHIFWrite = 0;
    settle();
    chk("t3_idle", {30'd0, arbGrant}, 32'h0);

    // downstream error on TX with RX pending
    txHIFRead = 1; rxHIFRead = 1;
    tick();
    dmaHIFError = 1;
    settle();
    chk("t4_grant", {30'd0, arbGrant}, 32'h1);
    chk("t4_txErr", {31'd0, txHIFError}, 32'h1);
    chk("t4_rxErr", {31'd0, rxHIFError}, 32'h0);
    tick();
    dmaHIFError = 0; txHIFRead = 0;
    settle();
    chk("t4_idle", {30'd0, arbGrant}, 32'h0);
    chk("t4_txErrOff", {31'd0, txHIFError}, 32'h0);
    tick(); settle();
    chk("t4_rxGrant", {30'd0, arbGrant}, 32'h2);
    dmaHIFTransComplete = 1;
    tick();
    dmaHIFTransComplete = 0; rxHIFRead = 0;

    // async reset mid TX grant; the next tie must go to TX again
    txHIFRead = 1;
    tick();
    dmaHIFReady = 1;
    settle();
    chk("t5_pre", {30'd0, arbGrant}, 32'h1);
    macPIClkHardRst = 1;
    settle();
    chk("t5_grant", {30'd0, arbGrant}, 32'h0);
    chk("t5_dmaRd", {31'd0, dmaHIFRead}, 32'h0);
    chk("t5_txRdy", {31'd0, txHIFReady}, 32'h0);
    tick();
    macPIClkHardRst = 0; dmaHIFReady = 0; rxHIFRead = 1;
    tick(); settle();
    chk("t5_tie", {30'd0, arbGrant}, 32'h1);
    dmaHIFTransComplete = 1;
    tick();
    dmaHIFTransComplete = 0; txHIFRead = 0; rxHIFRead = 0;
    tick();
    dmaHIFTransComplete = 1;
    tick();
    dmaHIFTransComplete = 0;

    // stall with no handshake
    doReset();
    txHIFRead = 1;
    tick();
`ifdef RW_HIF_ARB_WDOG_EN
    for (int i = 1; i <= 8; i++) begin
      settle();
      chk($sformatf("t6_err%0d", i), {31'd0, txHIFError}, {31'd0, i == 8});
      chk($sformatf("t6_rd%0d", i), {31'd0, dmaHIFRead}, {31'd0, i != 8});
      if (i < 8) tick();
    end
    tick();
    txHIFRead = 0;
    settle();
    chk("t6_idle", {30'd0, arbGrant}, 32'h0);
    chk("t6_sticky", {31'd0, arbWdogErr}, 32'h1);
    txHIFRead = 1;
    tick();
    dmaHIFTransComplete = 1;
    tick();
    dmaHIFTransComplete = 0; txHIFRead = 0;
    settle();
    chk("t6_stillSet", {31'd0, arbWdogErr}, 32'h1);
    doReset();
    chk("t6_cleared", {31'd0, arbWdogErr}, 32'h0);
`else
    repeat (40) tick();
    settle();
    chk("t6_held", {30'd0, arbGrant}, 32'h1);
    chk("t6_noErr", {31'd0, txHIFError}, 32'h0);
    chk("t6_noWdog", {31'd0, arbWdogErr}, 32'h0);
    dmaHIFTransComplete = 1;
    tick();
    dmaHIFTransComplete = 0; txHIFRead = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
